seg_chase_monitor: RTL and testbench

Checks the animated segment chase on a seven-segment display. The block samples an active-low segment bus on a tick strobe and filters out glitches. It decodes each stable pattern to one of 12 chase positions and checks that positions arrive in order and are held for the expected time. It sits on the receiving side of the HEX chase driver, either as a self-check monitor on HEX0 or as a decoder for a segment bus arriving from another board.

---
 rtl/seg_chase_monitor.sv | 190 +++++++++++++++++++
 tb/tb_seg_chase_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_chase_monitor.sv
// seg_chase_monitor
// Receives an active-low seven-segment bus and checks the animated segment
// chase on it. The bus is sampled on each sample_en strobe and passed through
// a stability filter. Each stable pattern is decoded to one of 12 chase
// positions. The block then checks that positions arrive in order and tracks
// how long each one was held.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   sample_en  in   one-cycle sample strobe
//   seg_in     in   [6:0] active-low segments, bit0=a .. bit6=g
//   pos        out  [3:0] last accepted position 0..11
//   pos_valid  out  one-cycle pulse when pos updates
//   locked     out  high while the chase order is being followed
//   seq_err    out  one-cycle pulse on an order, illegal-pattern or dwell error
//   dwell      out  [3:0] hold length of the previous position, saturating at 15
//   err_count  out  [7:0] error count, saturating at 255
//
// Optional feature: define SEG_CHASE_DWELL_CHECK_EN to check the hold time of
// each position while locked (even positions LONG_HOLD, odd SHORT_HOLD, +/-1).
module seg_chase_monitor #(
    parameter int unsigned STABLE_COUNT = 4,
    parameter int unsigned LONG_HOLD    = 10,
    parameter int unsigned SHORT_HOLD   = 5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [6:0] seg_in,
    output logic [3:0] pos,
    output logic       pos_valid,
    output logic       locked,
    output logic       seq_err,
    output logic [3:0] dwell,
    output logic [7:0] err_count
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] INVALID  = 4'd15;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);
    localparam logic [CW-1:0] DMAX     = 4'd15;

    // Acceptable dwell windows, widened by one bit so +1 never wraps
    localparam logic [4:0] LONG_LO  = 5'((LONG_HOLD  > 0) ? LONG_HOLD  - 1 : 0);
    localparam logic [4:0] LONG_HI  = 5'(LONG_HOLD  + 1);
    localparam logic [4:0] SHORT_LO = 5'((SHORT_HOLD > 0) ? SHORT_HOLD - 1 : 0);
    localparam logic [4:0] SHORT_HI = 5'(SHORT_HOLD + 1);

`ifdef SEG_CHASE_DWELL_CHECK_EN
    localparam bit DWELL_CHECK = 1'b1;
`else
    localparam bit DWELL_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cand;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_dctr;
    logic          r_pos_vld;

    logic [CW-1:0] w_dec;
    logic          w_match;
    logic          w_accept;
    logic          w_inv;
    logic          w_vacc;
    logic [CW-1:0] w_succ;
    logic [CW-1:0] w_new_dwell;
    logic          w_order_err;
    logic          w_dwell_err;
    logic [4:0]    w_exp_lo;
    logic [4:0]    w_exp_hi;
    logic [8:0]    w_err_sum;
    logic [7:0]    w_err_nxt;

    // Segment pattern to chase position; anything else is INVALID
    function automatic logic [CW-1:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 4'd0;
            7'b1111100: decode = 4'd1;
            7'b1111101: decode = 4'd2;
            7'b1111001: decode = 4'd3;
            7'b1111011: decode = 4'd4;
            7'b1110011: decode = 4'd5;
            7'b1110111: decode = 4'd6;
            7'b1100111: decode = 4'd7;
            7'b1101111: decode = 4'd8;
            7'b1001111: decode = 4'd9;
            7'b1011111: decode = 4'd10;
            7'b1011110: decode = 4'd11;
            default:    decode = INVALID;
        endcase
    endfunction

    // Filter, acceptance and dwell datapath
    always_comb begin
        w_dec       = decode(seg_in);
        w_match     = (w_dec == r_cand);
        // Fires only on the sample that brings cnt to STABLE_COUNT; the
        // current position is not re-accepted after a glitch returns to it
        w_accept    = sample_en && w_match && (r_cnt == CNT_LAST)
                      && !(r_pos_vld && (w_dec == pos));
        w_inv       = (w_dec == INVALID);
        w_vacc      = w_accept && !w_inv;
        w_succ      = (pos == 4'd11) ? 4'd0 : pos + 4'd1;
        w_new_dwell = (r_dctr == DMAX) ? DMAX : r_dctr + 4'd1;
        w_exp_lo    = pos[0] ? SHORT_LO : LONG_LO;
        w_exp_hi    = pos[0] ? SHORT_HI : LONG_HI;
        w_dwell_err = DWELL_CHECK && w_vacc && (r_state == LOCK)
                      && (({1'b0, w_new_dwell} < w_exp_lo) ||
                          ({1'b0, w_new_dwell} > w_exp_hi));
    end

    // Chase-order FSM next state and order-error detection
    always_comb begin
        w_state_nxt = r_state;
        w_order_err = 1'b0;
        if (w_accept) begin
            if (w_inv) begin
                w_state_nxt = IDLE;
                w_order_err = 1'b1;
            end else begin
                case (r_state)
                    IDLE: w_state_nxt = ACQ;
                    ACQ:  w_state_nxt = (w_dec == w_succ) ? LOCK : ACQ;
                    LOCK: begin
                        if (w_dec != w_succ) begin
                            w_state_nxt = ACQ;
                            w_order_err = 1'b1;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end
    end

    // Order and dwell errors on the same accept both count
    always_comb begin
        w_err_sum = {1'b0, err_count} + 9'(w_order_err) + 9'(w_dwell_err);
        w_err_nxt = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end

    // State and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cand    <= INVALID;
            r_cnt     <= '0;
            r_dctr    <= '0;
            r_pos_vld <= 1'b0;
            pos       <= '0;
            pos_valid <= 1'b0;
            locked    <= 1'b0;
            seq_err   <= 1'b0;
            dwell     <= '0;
            err_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            locked    <= (w_state_nxt == LOCK);
            pos_valid <= w_vacc;
            seq_err   <= w_order_err | w_dwell_err;
            err_count <= w_err_nxt;
            if (sample_en) begin
                if (w_match) begin
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 4'd1;
                end else begin
                    r_cand <= w_dec;
                    r_cnt  <= 4'd1;
                end
                if (w_accept)          r_dctr <= '0;
                else if (r_dctr != DMAX) r_dctr <= r_dctr + 4'd1;
            end
            if (w_vacc) begin
                pos       <= w_dec;
                dwell     <= w_new_dwell;
                r_pos_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_chase_monitor.sv
// Scoreboard bench for seg_chase_monitor: each stimulus step pushes the
// expected output event; a negedge monitor pops and compares on every
// pos_valid / seq_err pulse.
module tb_seg_chase_monitor;

`ifdef SEG_CHASE_DWELL_CHECK_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    localparam logic [6:0] P_A  = 7'b1111110;
    localparam logic [6:0] P_AB = 7'b1111100;
    localparam logic [6:0] P_B  = 7'b1111101;
    localparam logic [6:0] P_BC = 7'b1111001;
    localparam logic [6:0] P_C  = 7'b1111011;
    localparam logic [6:0] P_D  = 7'b1110111;
    localparam logic [6:0] P_DE = 7'b1100111;
    localparam logic [6:0] P_F  = 7'b1011111;
    localparam logic [6:0] P_FA = 7'b1011110;

    logic       CLOCK_50;
    logic       reset;
    logic       sample_en;
    logic [6:0] seg_in;
    logic [3:0] pos;
    logic       pos_valid;
    logic       locked;
    logic       seq_err;
    logic [3:0] dwell;
    logic [7:0] err_count;

    typedef struct {
        logic       pv;
        logic       se;
        logic [3:0] pos;
        logic [3:0] dwell;
        logic       lk;
        logic [7:0] err;
    } ev_t;

    ev_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  exp_err = 0;

    seg_chase_monitor dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .sample_en(sample_en),
        .seg_in   (seg_in),
        .pos      (pos),
        .pos_valid(pos_valid),
        .locked   (locked),
        .seq_err  (seq_err),
        .dwell    (dwell),
        .err_count(err_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic pv, input logic se, input int p,
                        input int d, input logic lk, input int e);
        ev_t ev;
        ev.pv = pv; ev.se = se; ev.pos = 4'(p); ev.dwell = 4'(d);
        ev.lk = lk; ev.err = 8'(e);
        q.push_back(ev);
    endtask

    // n back-to-back samples of one pattern, then one idle cycle
    task automatic hold(input logic [6:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            sample_en = 1'b1;
            seg_in    = p;
        end
        @(negedge CLOCK_50);
        sample_en = 1'b0;
        seg_in    = 7'h7F;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pos"},       int'(pos),       0);
        chk({tag, "_pos_valid"}, int'(pos_valid), 0);
        chk({tag, "_locked"},    int'(locked),    0);
        chk({tag, "_seq_err"},   int'(seq_err),   0);
        chk({tag, "_dwell"},     int'(dwell),     0);
        chk({tag, "_err_count"}, int'(err_count), 0);
    endtask

    // Monitor: compare every output event against the scoreboard head
    always @(negedge CLOCK_50) begin
        if (!reset && (pos_valid || seq_err)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_pos_valid", int'(pos_valid), int'(e.pv));
                chk("ev_seq_err",   int'(seq_err),   int'(e.se));
                chk("ev_pos",       int'(pos),       int'(e.pos));
                chk("ev_dwell",     int'(dwell),     int'(e.dwell));
                chk("ev_locked",    int'(locked),    int'(e.lk));
                chk("ev_err_count", int'(err_count), int'(e.err));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        sample_en = 1'b0;
        seg_in    = 7'h7F;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        chk_zero("reset");

        // Legal chase a, ab, b, bc
        push(1, 0, 0, 4, 0, 0);   hold(P_A, 10);
        push(1, 0, 1, 10, 1, 0);  hold(P_AB, 5);
        push(1, 0, 2, 5, 1, 0);   hold(P_B, 10);
        push(1, 0, 3, 10, 1, 0);  hold(P_BC, 5);

        // Glitch: next position for 3 samples only, then back
        hold(P_C, 3);
        hold(P_BC, 4);
        chk("glitch_locked", int'(locked), 1);
        chk("glitch_pos",    int'(pos),    3);

        // Order error: jump from 3 to 6 (dwell 12 also off-window if checked)
        exp_err = DC ? 2 : 1;
        push(1, 1, 6, 12, 0, exp_err); hold(P_D, 4);
        push(1, 0, 7, 4, 1, exp_err);  hold(P_DE, 4);

        // Illegal pattern while locked
        exp_err++;
        push(0, 1, 7, 4, 0, exp_err);  hold(7'b0000000, 4);

        // Reacquire at f, then fa -> a wrap stays locked
        push(1, 0, 10, 4, 0, exp_err); hold(P_F, 10);
        push(1, 0, 11, 10, 1, exp_err); hold(P_FA, 5);
        push(1, 0, 0, 5, 1, exp_err);   hold(P_A, 4);
        chk("wrap_locked", int'(locked), 1);

        // Reset on the cycle that would accept ab
        hold(P_AB, 3);
        @(negedge CLOCK_50);
        sample_en = 1'b1;
        seg_in    = P_AB;
        reset     = 1'b1;
        @(negedge CLOCK_50);
        sample_en = 1'b0;
        seg_in    = 7'h7F;
        reset     = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        chk_zero("rst_accept");

        // ab held 8 samples in LOCK: dwell 8 against expected 5
        push(1, 0, 0, 4, 0, 0);   hold(P_A, 10);
        push(1, 0, 1, 10, 1, 0);  hold(P_AB, 8);
        exp_err = DC ? 1 : 0;
        push(1, DC, 2, 8, 1, exp_err); hold(P_B, 4);

        repeat (3) @(negedge CLOCK_50);
        chk("events_pending", q.size(), 0);
        chk("final_locked", int'(locked), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
